// File: rtl/spi_slave_lbus_param.sv
// SPI (mode 0) slave bridging command/address/data frames onto a simple local bus.
// Latency: strobes fire at the sclk posedge that samples a field's last bit; miso loads on the following negedge.
// Backpressure: none; the local bus must return rdata while rd_en is high and accept every wr_en pulse.
module spi_slave_lbus_param #(
    parameter int ADDR_BYTES = 2,
    parameter int DATA_BYTES = 1,
    parameter int AUTO_INC   = 1
) (
    input  logic                    sclk,
    input  logic                    reset_spi_n,
    input  logic                    mosi,
    output logic                    miso,
    input  logic [8*DATA_BYTES-1:0] rdata,
    input  logic [7:0]              status,
    output logic                    rd_en,
    output logic                    wr_en,
    output logic [8*DATA_BYTES-1:0] wdata,
    output logic [8*ADDR_BYTES-1:0] address
);

    localparam int AW = 8 * ADDR_BYTES;
    localparam int DW = 8 * DATA_BYTES;

    localparam logic [7:0] OP_WRITE = 8'h01;
    localparam logic [7:0] OP_READ  = 8'h02;
    localparam logic [7:0] OP_FAST  = 8'h0B;
    localparam logic [7:0] OP_STAT  = 8'h05;

    typedef enum logic [2:0] {
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_WDATA,
        ST_RDATA,
        ST_STAT,
        ST_IGNORE
    } state_t;

    state_t          state;
    logic [5:0]      bit_cnt;   // bit position inside the current field
    logic [7:0]      cmd_sr;    // holds the opcode once the command byte is complete
    logic [AW-1:0]   addr_sr;
    logic [DW-1:0]   wr_sr;
    logic [DW-1:0]   tx_sr;     // negedge domain: miso is its MSB

    logic            byte_last;
    logic            addr_last;
    logic            word_last;
    logic [7:0]      cmd_next;
    logic [AW-1:0]   addr_next;
    logic [DW-1:0]   word_next;

    assign byte_last = (bit_cnt == 6'd7);
    assign addr_last = (bit_cnt == 6'(AW - 1));
    assign word_last = (bit_cnt == 6'(DW - 1));
    assign cmd_next  = {cmd_sr[6:0], mosi};
    assign addr_next = {addr_sr[AW-2:0], mosi};
    assign word_next = {wr_sr[DW-2:0], mosi};

    // Frame sequencer: samples mosi, tracks field boundaries, issues strobes and address updates.
    always_ff @(posedge sclk or negedge reset_spi_n) begin
        if (!reset_spi_n) begin
            state   <= ST_CMD;
            bit_cnt <= '0;
            cmd_sr  <= '0;
            addr_sr <= '0;
            wr_sr   <= '0;
            rd_en   <= 1'b0;
            wr_en   <= 1'b0;
            wdata   <= '0;
            address <= '0;
        end else begin
            rd_en <= 1'b0;
            wr_en <= 1'b0;
            case (state)
                ST_CMD: begin
                    cmd_sr <= cmd_next;
                    if (byte_last) begin
                        bit_cnt <= '0;
                        case (cmd_next)
                            OP_WRITE, OP_READ, OP_FAST: state <= ST_ADDR;
                            OP_STAT:                    state <= ST_STAT;
                            default:                    state <= ST_IGNORE;
                        endcase
                    end else begin
                        bit_cnt <= bit_cnt + 6'd1;
                    end
                end
                ST_ADDR: begin
                    addr_sr <= addr_next;
                    if (addr_last) begin
                        bit_cnt <= '0;
                        address <= addr_next;
                        if (cmd_sr == OP_WRITE) begin
                            state <= ST_WDATA;
                        end else if (cmd_sr == OP_READ) begin
                            rd_en <= 1'b1;
                            state <= ST_RDATA;
                        end else begin
                            state <= ST_DUMMY;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 6'd1;
                    end
                end
                ST_DUMMY: begin
                    if (byte_last) begin
                        bit_cnt <= '0;
                        rd_en   <= 1'b1;
                        state   <= ST_RDATA;
                    end else begin
                        bit_cnt <= bit_cnt + 6'd1;
                    end
                end
                ST_WDATA: begin
                    wr_sr <= word_next;
                    // Advance one cycle after the write strobe so the bus sees the old address with it.
                    if (wr_en && AUTO_INC != 0) begin
                        address <= address + AW'(1);
                    end
                    if (word_last) begin
                        bit_cnt <= '0;
                        wdata   <= word_next;
                        wr_en   <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 6'd1;
                    end
                end
                ST_RDATA: begin
                    // Prefetch the next word while its predecessor's last bit is on the wire.
                    if (word_last) begin
                        bit_cnt <= '0;
                        rd_en   <= 1'b1;
                        if (AUTO_INC != 0) begin
                            address <= address + AW'(1);
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 6'd1;
                    end
                end
                ST_STAT: begin
                    bit_cnt <= byte_last ? 6'd0 : bit_cnt + 6'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Transmit shifter: loads read data or status on the falling edge, then shifts one bit per negedge.
    always_ff @(negedge sclk or negedge reset_spi_n) begin
        if (!reset_spi_n) begin
            tx_sr <= '0;
        end else if (rd_en) begin
            tx_sr <= rdata;
        end else if (state == ST_STAT && bit_cnt == 6'd0) begin
            tx_sr <= DW'(status) << (DW - 8);
        end else if (state == ST_RDATA || state == ST_STAT) begin
            tx_sr <= tx_sr << 1;
        end else begin
            tx_sr <= '0;
        end
    end

    assign miso = tx_sr[DW-1];

endmodule

// File: tb/tb_spi_slave_lbus_param.sv
// Bench for spi_slave_lbus_param: default instance plus a 3-byte-address, 4-byte-data, no-increment instance.
// Latency: strobes checked on the negedge after they rise; miso sampled 1 time unit after each posedge.
// Backpressure: none; rdata is served from a queue after each observed read strobe.
module tb_spi_slave_lbus_param;

    logic        sclk = 1'b0;
    logic        rst1_n = 1'b0;
    logic        rst2_n = 1'b0;
    logic        mosi = 1'b0;
    logic [7:0]  status = 8'h00;

    logic        miso1, rd1, wr1;
    logic [7:0]  rdata1 = 8'h00;
    logic [7:0]  wdata1;
    logic [15:0] addr1;

    logic        miso2, rd2, wr2;
    logic [31:0] rdata2 = 32'h0;
    logic [31:0] wdata2;
    logic [23:0] addr2;

    int checks = 0;
    int errors = 0;
    int strobes = 0;

    typedef struct {
        int          inst;
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] dat;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] rd_q[$];
    exp_t       mon_e;

    always #5 sclk = ~sclk;

    spi_slave_lbus_param dut1 (
        .sclk(sclk), .reset_spi_n(rst1_n), .mosi(mosi), .miso(miso1),
        .rdata(rdata1), .status(status), .rd_en(rd1), .wr_en(wr1),
        .wdata(wdata1), .address(addr1)
    );

    spi_slave_lbus_param #(.ADDR_BYTES(3), .DATA_BYTES(4), .AUTO_INC(0)) dut2 (
        .sclk(sclk), .reset_spi_n(rst2_n), .mosi(mosi), .miso(miso2),
        .rdata(rdata2), .status(status), .rd_en(rd2), .wr_en(wr2),
        .wdata(wdata2), .address(addr2)
    );

    // Strobe monitor: pops the scoreboard on every strobe and serves the next read word.
    initial begin
        forever begin
            @(negedge sclk);
            if ((rd1 && wr1) || (rd2 && wr2)) begin
                checks++;
                errors++;
                $display("FAIL strobe_overlap: rd_en and wr_en both high at %0t", $time);
            end
            for (int k = 1; k <= 2; k++) begin
                bit          w, r;
                logic [31:0] a, d;
                w = (k == 1) ? wr1 : wr2;
                r = (k == 1) ? rd1 : rd2;
                a = (k == 1) ? {16'h0, addr1} : {8'h0, addr2};
                d = (k == 1) ? {24'h0, wdata1} : wdata2;
                if (w || r) begin
                    strobes++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_strobe: inst %0d wr %0b addr %h, none expected", k, w, a);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if (mon_e.inst != k || mon_e.is_wr !== w || mon_e.addr !== a ||
                            (w && mon_e.dat !== d)) begin
                            errors++;
                            $display("FAIL strobe: got inst %0d wr %0b addr %h data %h, want inst %0d wr %0b addr %h data %h",
                                     k, w, a, d, mon_e.inst, mon_e.is_wr, mon_e.addr, mon_e.dat);
                        end
                    end
                end
            end
            if (rd1) begin
                #2;
                if (rd_q.size() > 0) rdata1 = rd_q.pop_front();
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Drive n bits MSB first while releasing the selected instance; returns miso bits in the same order.
    task automatic xfer(input int which, input logic [127:0] tx, input int n, output logic [127:0] rx);
        rx = '0;
        @(negedge sclk);
        mosi = tx[n-1];
        #2;
        if (which == 2) rst2_n = 1'b1;
        else            rst1_n = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge sclk);
            #1;
            rx = {rx[126:0], miso1};
            @(negedge sclk);
            if (i < n - 1) mosi = tx[n-2-i];
        end
    endtask

    task automatic end_xfer();
        #3;
        rst1_n = 1'b0;
        rst2_n = 1'b0;
        mosi   = 1'b0;
        rdata1 = 8'h00;
        rd_q.delete();
        @(negedge sclk);
    endtask

    task automatic check_tail(input string name, input int s0, input int want_strobes);
        checks++;
        if (strobes - s0 != want_strobes || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_strobes: got %0d strobes (%0d expected left), want %0d strobes (0 left)",
                     name, strobes - s0, exp_q.size(), want_strobes);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge sclk);
        #1;
        checks++;
        if ({miso1, rd1, wr1, wdata1, addr1} !== 27'h0) begin
            errors++;
            $display("FAIL reset_dut1: got %h, want 0", {miso1, rd1, wr1, wdata1, addr1});
        end
        checks++;
        if ({miso2, rd2, wr2, wdata2, addr2} !== 59'h0) begin
            errors++;
            $display("FAIL reset_dut2: got %h, want 0", {miso2, rd2, wr2, wdata2, addr2});
        end
    endtask

    task automatic test_write();
        logic [127:0] tx, rx;
        int s0 = strobes;
        exp_q.push_back('{1, 1'b1, 32'h1234, 32'hA5});
        exp_q.push_back('{1, 1'b1, 32'h1235, 32'h5A});
        tx = 128'({8'h01, 16'h1234, 8'hA5, 8'h5A, 4'h3});
        xfer(1, tx, 44, rx);
        checks++;
        if (addr1 !== 16'h1236) begin
            errors++;
            $display("FAIL write_final_addr: got %h, want 1236", addr1);
        end
        checks++;
        if (wdata1 !== 8'h5A) begin
            errors++;
            $display("FAIL write_partial_word: wdata got %h, want 5a", wdata1);
        end
        checks++;
        if (rx !== 128'h0) begin
            errors++;
            $display("FAIL write_miso: got %h, want 0", rx);
        end
        check_tail("write", s0, 2);
        end_xfer();
    endtask

    task automatic test_read(input bit fast);
        logic [127:0] tx, rx;
        logic [15:0]  base;
        int           n;
        int s0 = strobes;
        base   = fast ? 16'hFFFF : 16'h0010;
        rdata1 = fast ? 8'h96 : 8'hC3;
        rd_q.push_back(fast ? 8'h69 : 8'h3C);
        rd_q.push_back(8'h00);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('{1, 1'b0, {16'h0, base + 16'(i)}, 32'h0});
        end
        if (fast) begin
            tx = 128'({8'h0B, 16'hFFFF, 8'hFF, 16'h0000});
            n  = 48;
        end else begin
            tx = 128'({8'h02, 16'h0010, 16'h0000});
            n  = 40;
        end
        xfer(1, tx, n, rx);
        checks++;
        if (rx[15:0] !== (fast ? 16'h9669 : 16'hC33C)) begin
            errors++;
            $display("FAIL read_miso_data(fast=%0d): got %h, want %h", fast, rx[15:0], fast ? 16'h9669 : 16'hC33C);
        end
        checks++;
        if ((rx >> 16) !== 128'h0) begin
            errors++;
            $display("FAIL read_miso_preamble(fast=%0d): got %h, want 0", fast, rx >> 16);
        end
        check_tail(fast ? "fast_read" : "read", s0, 3);
        end_xfer();
    endtask

    task automatic test_status();
        logic [127:0] tx, rx;
        logic [7:0]   vals [2];
        vals[0] = 8'h81;
        vals[1] = 8'h4D;
        for (int v = 0; v < 2; v++) begin
            int s0 = strobes;
            status = vals[v];
            tx = 128'({8'h05, 24'hFFFFFF});
            xfer(1, tx, 32, rx);
            checks++;
            if (rx[23:0] !== {3{vals[v]}}) begin
                errors++;
                $display("FAIL status_miso: got %h, want %h", rx[23:0], {3{vals[v]}});
            end
            checks++;
            if (rx[31:24] !== 8'h00) begin
                errors++;
                $display("FAIL status_cmd_miso: got %h, want 00", rx[31:24]);
            end
            check_tail("status", s0, 0);
            end_xfer();
        end
    endtask

    task automatic test_ignore_abort();
        logic [127:0] tx, rx;
        int s0 = strobes;
        tx = 128'({8'h7E, 32'hFFFFFFFF});
        xfer(1, tx, 40, rx);
        checks++;
        if (rx !== 128'h0 || addr1 !== 16'h0 || wdata1 !== 8'h0) begin
            errors++;
            $display("FAIL ignore: miso %h addr %h wdata %h, want all 0", rx, addr1, wdata1);
        end
        check_tail("ignore", s0, 0);
        end_xfer();

        s0 = strobes;
        tx = 128'({8'h01, 16'h1234, 4'hA});
        xfer(1, tx, 28, rx);
        checks++;
        if (addr1 !== 16'h1234) begin
            errors++;
            $display("FAIL abort_mid_addr: got %h, want 1234", addr1);
        end
        end_xfer();
        #1;
        checks++;
        if ({miso1, rd1, wr1, wdata1, addr1} !== 27'h0) begin
            errors++;
            $display("FAIL abort_outputs: got %h, want 0", {miso1, rd1, wr1, wdata1, addr1});
        end
        check_tail("abort", s0, 0);
    endtask

    task automatic test_wide_no_inc();
        logic [127:0] tx, rx;
        int s0 = strobes;
        exp_q.push_back('{2, 1'b1, 32'h0A0B0C, 32'hDEADBEEF});
        exp_q.push_back('{2, 1'b1, 32'h0A0B0C, 32'hDEADBEEF});
        tx = 128'({8'h01, 24'h0A0B0C, 32'hDEADBEEF, 32'hDEADBEEF, 8'h55});
        xfer(2, tx, 104, rx);
        checks++;
        if (addr2 !== 24'h0A0B0C || wdata2 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL wide_final: addr %h wdata %h, want 0a0b0c deadbeef", addr2, wdata2);
        end
        checks++;
        if (miso2 !== 1'b0) begin
            errors++;
            $display("FAIL wide_miso: got %b, want 0", miso2);
        end
        check_tail("wide", s0, 2);
        end_xfer();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read(1'b0);
        test_read(1'b1);
        test_status();
        test_ignore_abort();
        test_wide_no_inc();
        repeat (2) @(negedge sclk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
